// File: rtl/riscv_defs.sv
// Shared RV32I definitions: opcodes, multi-cycle state encodings and datapath select codes.
// The single-cycle decoder imports the same opcode constants.
package riscv_defs;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_EXEC_I   = 4'd3,
    ST_WB_ALU   = 4'd4,
    ST_MEM_ADDR = 4'd5,
    ST_MEM_RD   = 4'd6,
    ST_MEM_WR   = 4'd7,
    ST_WB_MEM   = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JAL      = 4'd10,
    ST_JALR     = 4'd11,
    ST_TRAP     = 4'd12
  } state_e;

  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLDPC  = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;

  localparam logic [1:0] SRCB_RS2    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_ALU_A  = 2'b10;

  localparam logic [1:0] M2R_ALUOUT  = 2'b00;
  localparam logic [1:0] M2R_MEM     = 2'b01;
  localparam logic [1:0] M2R_PC      = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
  localparam logic [1:0] ALUOP_JUMP   = 2'b11;

  // Full set of Moore controls for one state; retire is internal to the counter too.
  typedef struct packed {
    logic       mem_req;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       retire;
  } ctrl_t;

endpackage

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencing FSM: per-instruction state walk, memory handshake,
// datapath selects, retired-instruction counter and sticky illegal-opcode flag.
module multicycle_controller
  import riscv_defs::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             AdrSrc,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       PCSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             RegWrite,
  output logic [1:0]       MemToReg,
  output logic             retire,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             illegal,
  output state_e           state_dbg
);

  // Memory handshake: mem_req with address/strobes is held stable until the cycle
  // in which mem_ready=1 completes it; mem_ready is ignored in every other state.

  state_e             state, state_next;
  ctrl_t              ctrl, ctrl_out;
  logic [CNT_W-1:0]   cnt_q;
  logic               illegal_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_next;
      if (ctrl.retire) cnt_q <= cnt_q + CNT_W'(1);
      if (state_next == ST_TRAP) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    ctrl       = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.adr_src   = 1'b0;
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        if (mem_ready) state_next = ST_DECODE;
      end
      ST_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        case (opcode)
          OP_R:               state_next = ST_EXEC_R;
          OP_IMM:             state_next = ST_EXEC_I;
          OP_LOAD, OP_STORE:  state_next = ST_MEM_ADDR;
          OP_BRANCH:          state_next = ST_BRANCH;
          OP_JAL:             state_next = ST_JAL;
          OP_JALR:            state_next = ST_JALR;
          default:            state_next = ST_TRAP;
        endcase
      end
      ST_EXEC_R: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALUOP_FUNCT;
        state_next     = ST_WB_ALU;
      end
      ST_EXEC_I: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_FUNCT;
        state_next     = ST_WB_ALU;
      end
      ST_WB_ALU: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_ALUOUT;
        ctrl.retire     = 1'b1;
        state_next      = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        state_next     = (opcode == OP_LOAD) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        ctrl.mem_req  = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.adr_src  = 1'b1;
        if (mem_ready) state_next = ST_WB_MEM;
      end
      ST_MEM_WR: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.adr_src   = 1'b1;
        ctrl.retire    = mem_ready;
        if (mem_ready) state_next = ST_FETCH;
      end
      ST_WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_MEM;
        ctrl.retire     = 1'b1;
        state_next      = ST_FETCH;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALUOP_BRANCH;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.pc_write  = zero;
        ctrl.retire    = 1'b1;
        state_next     = ST_FETCH;
      end
      ST_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_PC;
        ctrl.pc_write   = 1'b1;
        ctrl.pc_src     = PCSRC_ALUOUT;
        ctrl.retire     = 1'b1;
        state_next      = ST_FETCH;
      end
      ST_JALR: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.alu_op     = ALUOP_JUMP;
        ctrl.pc_src     = PCSRC_ALU_A;
        ctrl.pc_write   = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_PC;
        ctrl.retire     = 1'b1;
        state_next      = ST_FETCH;
      end
      ST_TRAP:  state_next = ST_TRAP;
      default:  state_next = ST_FETCH;
    endcase
  end

  // Reset is level-acting on the outputs so no strobe escapes during an aborted access.
  always_comb begin
    ctrl_out = rst_n ? ctrl : '0;
  end

  assign mem_req    = ctrl_out.mem_req;
  assign AdrSrc     = ctrl_out.adr_src;
  assign MemRead    = ctrl_out.mem_read;
  assign MemWrite   = ctrl_out.mem_write;
  assign IRWrite    = ctrl_out.ir_write;
  assign PCWrite    = ctrl_out.pc_write;
  assign PCSrc      = ctrl_out.pc_src;
  assign ALUSrcA    = ctrl_out.alu_src_a;
  assign ALUSrcB    = ctrl_out.alu_src_b;
  assign ALUOp      = ctrl_out.alu_op;
  assign RegWrite   = ctrl_out.reg_write;
  assign MemToReg   = ctrl_out.mem_to_reg;
  assign retire     = ctrl_out.retire;
  assign retire_cnt = rst_n ? cnt_q : '0;
  assign illegal    = rst_n & illegal_q;
  assign state_dbg  = rst_n ? state : ST_FETCH;

endmodule
